// File: rtl/program_loader.sv
// Program memory loader: fills a 2^ADDR_W x DATA_W program store from a
// high-byte-first host stream and gates the core until a full load completes.
module program_loader #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_count,
  input  logic              load_abort,
  input  logic [7:0]        in_byte,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] program_data_address,
  output logic [DATA_W-1:0] program_data,
  output logic              cpu_enable,
  output logic              busy,
  output logic              load_done,
  output logic [7:0]        checksum
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HI,
    S_LO,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [ADDR_W-1:0] r_count;
  logic [ADDR_W-1:0] r_index;
  logic [7:0]        r_hold;
  logic [7:0]        r_checksum;
  logic              r_loaded;
  logic              r_load_done;
  logic [DATA_W-1:0] r_program_data;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_in_ready;
  logic              w_busy;
  logic              w_accept;
  logic              w_last;
  logic              w_we;
  logic [ADDR_W-1:0] w_count_m1;
  logic [DATA_W-1:0] w_word;

  // A count of 0 wraps to all-ones, so the last index is 2^ADDR_W-1.
  assign w_count_m1 = r_count - ADDR_W'(1);
  assign w_last     = (r_index == w_count_m1);
  assign w_accept   = in_valid & w_in_ready & ~load_abort;
  assign w_we       = w_accept & (r_state == S_LO);
  assign w_word     = DATA_W'({r_hold, in_byte});

  // NOTE: sequential state always uses non-blocking assignments so every
  // register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: the default assignment before the case keeps this purely
  // combinational; a missing branch would otherwise infer a latch.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE: if (load_start) w_next_state = S_HI;
      S_HI: begin
        if (load_abort)    w_next_state = S_IDLE;
        else if (in_valid) w_next_state = S_LO;
      end
      S_LO: begin
        if (load_abort)    w_next_state = S_IDLE;
        else if (in_valid) w_next_state = w_last ? S_DONE : S_HI;
      end
      S_DONE: w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Handshake outputs decode the registered state only.
  always_comb begin
    w_in_ready = 1'b0;
    w_busy     = 1'b0;
    unique case (r_state)
      S_IDLE: ;
      S_HI, S_LO: begin
        w_in_ready = 1'b1;
        w_busy     = 1'b1;
      end
      S_DONE: w_busy = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count        <= '0;
      r_index        <= '0;
      r_hold         <= '0;
      r_checksum     <= '0;
      r_loaded       <= 1'b0;
      r_load_done    <= 1'b0;
      r_program_data <= '0;
    end else begin
      r_load_done    <= (r_state == S_DONE);
      r_program_data <= r_mem[program_data_address];
      if (r_state == S_IDLE && load_start) begin
        r_count    <= load_count;
        r_index    <= '0;
        r_checksum <= '0;
        r_loaded   <= 1'b0;
      end
      if (r_state == S_DONE) begin
        r_loaded <= 1'b1;
      end
      if (w_accept) begin
        r_checksum <= r_checksum ^ in_byte;
        if (r_state == S_HI) begin
          r_hold <= in_byte;
        end else if (!w_last) begin
          r_index <= r_index + ADDR_W'(1);
        end
      end
    end
  end

  // NOTE: the program store has no reset; its contents survive reset and
  // only the LO handshake writes it.
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[r_index] <= w_word;
    end
  end

  assign in_ready     = w_in_ready;
  assign busy         = w_busy;
  assign cpu_enable   = r_loaded;
  assign load_done    = r_load_done;
  assign checksum     = r_checksum;
  assign program_data = r_program_data;

endmodule

// File: doc/program_loader.md
# program_loader

Upstream stage of the control unit: owns the 256 x 16-bit program memory and fills it from a host byte stream (high byte first) over a valid/ready handshake. Serves the control unit's fetch port (`program_data_address` in, `program_data` out) with one-cycle registered reads. Gates the core through `cpu_enable`, which drives the control unit's `enable`. The core runs only after a complete, un-aborted load.

## Interface
- `DATA_W`, 16, program word width; equals `program_data_size`.
- `ADDR_W`, 8, program address width; equals `program_data_max_length`; depth = 2^ADDR_W.
- `clk`  in  1  single system clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `load_start`  in  1  one-cycle request to begin a load; honoured only in IDLE.
- `load_count`  in  ADDR_W  number of words to load, sampled with `load_start`; 0 means 2^ADDR_W.
- `load_abort`  in  1  abandon the load in progress.
- `in_byte`  in  8  host byte.
- `in_valid`  in  1  `in_byte` valid.
- `in_ready`  out  1  loader accepts a byte; a byte transfers on an edge where `in_valid & in_ready`.
- `program_data_address`  in  ADDR_W  fetch address from the control unit.
- `program_data`  out  DATA_W  fetched word.
- `cpu_enable`  out  1  drives control unit `enable`.
- `busy`  out  1  high in HI, LO and DONE.
- `load_done`  out  1  one-cycle pulse on successful completion.
- `checksum`  out  8  XOR of all accepted bytes of the current or last load.

## Operation
- **Reset values:** state IDLE; `cpu_enable`=0; `in_ready`=0; `busy`=0; `load_done`=0; `checksum`=0x00; `program_data`=0; internal `loaded` flag=0; word index=0; high-byte holding register=0. Memory contents are not reset.
- **States:** IDLE, HI, LO, DONE. Encoding is free. `in_ready` and `busy` decode the registered state only, so neither has a combinational path from inputs.
- **IDLE:**
  - `in_ready`=0.
  - `cpu_enable` = `loaded`.
  - On `load_start`:
    - latch `load_count`;
    - index←0, checksum←0, `loaded`←0, `cpu_enable`←0;
    - go to HI.
- **HI:** `in_ready`=1. On handshake, hold←`in_byte`, checksum ^= `in_byte`, go to LO.
- **LO:**
  - `in_ready`=1.
  - On handshake, write mem[index] ← {hold, `in_byte`} and checksum ^= `in_byte`.
  - If index == count-1 (count 0 treated as 2^ADDR_W; index width ADDR_W, compared modulo), go to DONE. Otherwise index++ and go to HI.
- **DONE:** lasts one cycle, then IDLE. On that exit edge, `load_done`←1 for one cycle, `loaded`←1, `cpu_enable`←1.
- **Abort:** `load_abort` in HI or LO returns to IDLE on the next edge.
  - `loaded` stays 0, so `cpu_enable` stays 0.
  - No write occurs on that edge, even if a handshake coincides.
  - Checksum holds its partial value.
  - `load_abort` in IDLE or DONE is ignored.
- **Ignored requests:** `load_start` outside IDLE is ignored, including during DONE. Abort takes priority over a simultaneous handshake.
- **Read port:** every edge, `program_data` ← mem[`program_data_address`], independent of state.
  - Read-during-write to the same address returns the old word.
  - While `cpu_enable`=0 the control unit ignores reads.
- **Single write port:** the LO handshake.

## Timing
- Fetch latency: 1 cycle, address at edge k gives data after edge k.
- Byte throughput: one byte per cycle when `in_valid` is held high; an N-word load takes 2N handshake cycles.
- Timeline from `load_start` sampled at edge s:
  - state HI and `cpu_enable`=0 after edge s;
  - first handshake possible at edge s+1;
  - with continuous valid, last handshake at edge s+2N;
  - DONE during cycle s+2N to s+2N+1;
  - `load_done` and `cpu_enable` high after edge s+2N+1.
- `in_valid` low in HI or LO stalls with no state change. `in_ready` does not depend on `in_valid`.
- Async reset mid-load:
  - all outputs go to reset values immediately, including `cpu_enable`=0;
  - memory keeps any words already written;
  - a new full load is required before the core runs.
- `load_count`=1: HI, then LO, then DONE. `load_count`=0: 256 words, index wraps only after the last write.

## Test plan
- **Basic load:** reset, `load_start` with count=2, bytes 0xD0,0x50,0xF0,0x00 on consecutive cycles → mem[0]=0xD050 and mem[1]=0xF000; `load_done` is a single pulse 1 cycle after the 4th handshake; `cpu_enable`=1; `checksum`=0x70.
- **Fetch port:** after the load, drive address 0 then 1 on consecutive edges → `program_data` reads 0xD050 then 0xF000, each one cycle later. With address 1 read while mem[1] is being rewritten, the old value is returned.
- **Backpressure and stalls:** random `in_valid` gaps during a 3-word load → words are correct; no byte is dropped or duplicated; `in_ready`=0 in IDLE before and after.
- **Abort:** start count=4, assert `load_abort` on the same edge as the 3rd byte handshake → IDLE next edge; mem[1] is unchanged; `cpu_enable` stays 0; no `load_done`. A subsequent full load is then accepted.
- **Full depth:** count=0, 512 bytes → all 256 words written, address 255 holds the last word, `load_done` fires once. `load_start` pulses issued mid-load are ignored.
- **Reset mid-load:** assert `reset` low between edges in LO → `in_ready`, `busy`, `cpu_enable` and `checksum` go to 0 immediately without a clock edge. After release, the loader is in IDLE with `cpu_enable`=0.
